mx11_seq: RTL

- Instruction sequencer for the mx11 scalar execution unit (SEU).
- Fetches 16-bit instruction words from program memory over a req/ack handshake and decodes them into SEU control fields (opcode, src_a, src_b, dst_f, fetch, cs_n).
- Issues one register-bank write strobe per retired instruction.
- Handles two-word load-immediate and halt. Sits between program memory and the SEU/register bank.

---
 rtl/mx11_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mx11_seq.sv
// mx11_seq: instruction sequencer for the mx11 scalar execution unit.
// Latency: ALU word is fetch + 1 execute cycle; LDI is fetch + immediate fetch + 1 load cycle.
// Backpressure: imem_req is held with a stable address until imem_ack; no other stalls.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   run, pc_start       - start request (IDLE/HALTED only) and start address
//   imem_req/addr/ack/rdata - program memory read handshake (rdata valid with ack)
//   seu_opcode/dst_f/src_a/src_b - IR fields driven to the SEU
//   seu_fetch, seu_cs_n - SEU immediate-load select and active-low chip select
//   reg_we, imm_data    - register-bank write strobe and LDI immediate byte
//   busy, halted, pc, retired - status: activity, halt, program counter, retired count
module mx11_seq #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [PC_W-1:0]  pc_start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic [3:0]       seu_opcode,
    output logic [3:0]       seu_dst_f,
    output logic [3:0]       seu_src_a,
    output logic [3:0]       seu_src_b,
    output logic             seu_fetch,
    output logic             seu_cs_n,
    output logic             reg_we,
    output logic [7:0]       imm_data,
    output logic             busy,
    output logic             halted,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_IMM    = 3'd3,
        S_LOADI  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_ir;
    logic [PC_W-1:0]  r_pc;
    logic [7:0]       r_imm;
    logic [CNT_W-1:0] r_retired;
    logic             r_imem_req;
    logic             r_cs_n;
    logic             r_fetch;
    logic             r_reg_we;
    logic             r_busy;
    logic             r_halted;

    logic             w_is_ldi;
    logic             w_is_halt;
    logic             w_retire;
    logic [PC_W-1:0]  w_pc_inc;

    // Decode is done on the word arriving from memory so the next state
    // can be chosen in the same cycle as the ack.
    assign w_is_ldi  = (imem_rdata[15:12] == 4'h0) && (imem_rdata[7:4] == 4'hF);
    assign w_is_halt = (imem_rdata[15:12] == 4'h0) && (imem_rdata[7:4] == 4'hE);
    assign w_pc_inc  = r_pc + PC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (run) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    if (w_is_halt)     w_state_nxt = S_HALTED;
                    else if (w_is_ldi) w_state_nxt = S_IMM;
                    else               w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:   w_state_nxt = S_FETCH;
            S_IMM:    if (imem_ack) w_state_nxt = S_LOADI;
            S_LOADI:  w_state_nxt = S_FETCH;
            S_HALTED: if (run) w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // EXEC and LOADI each last exactly one cycle, so entering either marks
    // exactly one retired instruction; the count is visible with reg_we.
    assign w_retire = (w_state_nxt == S_EXEC) || (w_state_nxt == S_LOADI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= 16'h0000;
            r_imm      <= 8'h00;
            r_retired  <= '0;
            r_imem_req <= 1'b0;
            r_cs_n     <= 1'b1;
            r_fetch    <= 1'b0;
            r_reg_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            case (r_state)
                S_IDLE, S_HALTED: if (run) r_pc <= pc_start;
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir <= imem_rdata;
                        r_pc <= w_pc_inc;
                    end
                end
                S_IMM: begin
                    if (imem_ack) begin
                        r_imm <= imem_rdata[7:0];
                        r_pc  <= w_pc_inc;
                    end
                end
                default: ;
            endcase

            if (w_retire && (r_retired != {CNT_W{1'b1}}))
                r_retired <= r_retired + CNT_W'(1);

            // Outputs are registered from the next state so they line up
            // with the state they describe without a decode after the flop.
            r_imem_req <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_IMM);
            r_cs_n     <= (w_state_nxt != S_EXEC);
            r_fetch    <= (w_state_nxt == S_LOADI);
            r_reg_we   <= w_retire;
            r_busy     <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) ||
                          (w_state_nxt == S_IMM)   || (w_state_nxt == S_LOADI);
            r_halted   <= (w_state_nxt == S_HALTED);
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign seu_opcode = r_ir[15:12];
    assign seu_dst_f  = r_ir[11:8];
    assign seu_src_a  = r_ir[7:4];
    assign seu_src_b  = r_ir[3:0];
    assign seu_fetch  = r_fetch;
    assign seu_cs_n   = r_cs_n;
    assign reg_we     = r_reg_we;
    assign imm_data   = r_imm;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign pc         = r_pc;
    assign retired    = r_retired;

endmodule
